// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: opcodes, functs, ALU ops,
// FSM states, pc_src and err_code values, plus funct decode helpers.
package multicycle_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SUB = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;

   localparam logic [1:0] PC_SRC_INC = 2'd0;
   localparam logic [1:0] PC_SRC_BR  = 2'd1;
   localparam logic [1:0] PC_SRC_JMP = 2'd2;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_ILLEGAL = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   // Codes 13..15 are unused and decode as HALT.
   typedef enum logic [3:0] {
      FETCH = 4'd0,
      DEC   = 4'd1,
      EXR   = 4'd2,
      WBR   = 4'd3,
      EXI   = 4'd4,
      WBI   = 4'd5,
      ADDR  = 4'd6,
      MEMRD = 4'd7,
      WBMEM = 4'd8,
      MEMWR = 4'd9,
      BR    = 4'd10,
      HALT  = 4'd11,
      JMP   = 4'd12
   } state_t;

   function automatic logic legalFunct(input logic [5:0] fn);
      return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
             (fn == FN_OR)  || (fn == FN_SLT);
   endfunction

   function automatic logic [3:0] functToAluOp(input logic [5:0] fn);
      case (fn)
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         FN_OR:   return ALU_OR;
         FN_SLT:  return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and status into the controller, enables out.
// master is the controller side, slave is the datapath side.
interface multicycle_ctrl_if #(
   parameter int ALU_OP_W = 4,
   parameter int RET_W    = 16
);
   logic [5:0]          opcode;
   logic [5:0]          funct;
   logic                zero;
   logic                mem_ready;
   logic                ir_write;
   logic                pc_write;
   logic [1:0]          pc_src;
   logic                reg_write;
   logic                reg_dst;
   logic                mem_to_reg;
   logic                alu_src;
   logic [ALU_OP_W-1:0] alu_op;
   logic                mem_read;
   logic                mem_write;
   logic                halted;
   logic [1:0]          err_code;
   logic [RET_W-1:0]    retired;

   modport master (
      input  opcode, funct, zero, mem_ready,
      output ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg, alu_src,
             alu_op, mem_read, mem_write, halted, err_code, retired
   );

   modport slave (
      output opcode, funct, zero, mem_ready,
      input  ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg, alu_src,
             alu_op, mem_read, mem_write, halted, err_code, retired
   );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts data-memory wait cycles; expired is high once TMO_MAX waits have accumulated.
// Synchronous clear on rst or clr, holds at TMO_MAX.
module mem_wait_timer #(
   parameter int TMO_W   = 4,
   parameter int TMO_MAX = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   logic [TMO_W-1:0] count;

   assign expired = (count == TMO_W'(TMO_MAX));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en && !expired) begin
         count <= count + TMO_W'(1);
      end
   end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer: FETCH/DEC/EX/MEM/WB one state per cycle, stalls in MEMRD/MEMWR until
// mem_ready, halts on illegal opcode or when the wait timer expires with mem_ready still low.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int ALU_OP_W = 4,
   parameter int TMO_W    = 4,
   parameter int TMO_MAX  = 15,
   parameter int RET_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   multicycle_ctrl_if.master bus
);
   state_t           state, nextState;
   logic [1:0]       errCode, errNext;
   logic [RET_W-1:0] retiredCnt;
   logic             timerExpired;

   logic       irWrite, pcWrite, regWrite, regDst, memToReg, aluSrc;
   logic       memRead, memWrite, isHalted;
   logic [1:0] pcSrc;
   logic [3:0] aluOp;

   // ADDR is the only way into MEMRD/MEMWR, so clearing there starts each access at zero.
   mem_wait_timer #(.TMO_W(TMO_W), .TMO_MAX(TMO_MAX)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (state == ADDR),
      .en      ((state == MEMRD || state == MEMWR) && !bus.mem_ready),
      .expired (timerExpired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FETCH;
         errCode    <= ERR_NONE;
         retiredCnt <= '0;
      end else begin
         state   <= nextState;
         errCode <= errNext;
         if (pcWrite) begin
            retiredCnt <= retiredCnt + RET_W'(1);
         end
      end
   end

   always_comb begin
      nextState = state;
      errNext   = errCode;
      case (state)
         FETCH: nextState = DEC;
         DEC: begin
            case (bus.opcode)
               OP_RTYPE: begin
                  if (legalFunct(bus.funct)) begin
                     nextState = EXR;
                  end else begin
                     nextState = HALT;
                     errNext   = ERR_ILLEGAL;
                  end
               end
               OP_LW, OP_SW: nextState = ADDR;
               OP_BEQ:       nextState = BR;
               OP_J:         nextState = JMP;
               OP_ADDI:      nextState = EXI;
               default: begin
                  nextState = HALT;
                  errNext   = ERR_ILLEGAL;
               end
            endcase
         end
         EXR:   nextState = WBR;
         WBR:   nextState = FETCH;
         EXI:   nextState = WBI;
         WBI:   nextState = FETCH;
         ADDR:  nextState = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
         MEMRD, MEMWR: begin
            // mem_ready wins over expiry on the last allowed cycle.
            if (bus.mem_ready) begin
               nextState = (state == MEMRD) ? WBMEM : FETCH;
            end else if (timerExpired) begin
               nextState = HALT;
               errNext   = ERR_TIMEOUT;
            end
         end
         WBMEM: nextState = FETCH;
         BR:    nextState = FETCH;
         JMP:   nextState = FETCH;
         HALT:  nextState = HALT;
         default: begin
            nextState = HALT;
            errNext   = ERR_ILLEGAL;
         end
      endcase
   end

   always_comb begin
      irWrite  = 1'b0;
      pcWrite  = 1'b0;
      pcSrc    = PC_SRC_INC;
      regWrite = 1'b0;
      regDst   = 1'b0;
      memToReg = 1'b0;
      aluSrc   = 1'b0;
      aluOp    = ALU_AND;
      memRead  = 1'b0;
      memWrite = 1'b0;
      isHalted = 1'b0;
      case (state)
         FETCH: irWrite = 1'b1;
         DEC: begin
         end
         EXR: aluOp = functToAluOp(bus.funct);
         WBR: begin
            aluOp    = functToAluOp(bus.funct);
            regWrite = 1'b1;
            regDst   = 1'b1;
            pcWrite  = 1'b1;
         end
         EXI, ADDR: begin
            aluSrc = 1'b1;
            aluOp  = ALU_ADD;
         end
         WBI: begin
            aluSrc   = 1'b1;
            aluOp    = ALU_ADD;
            regWrite = 1'b1;
            pcWrite  = 1'b1;
         end
         MEMRD: begin
            aluSrc  = 1'b1;
            aluOp   = ALU_ADD;
            memRead = 1'b1;
         end
         WBMEM: begin
            regWrite = 1'b1;
            memToReg = 1'b1;
            pcWrite  = 1'b1;
         end
         MEMWR: begin
            aluSrc   = 1'b1;
            aluOp    = ALU_ADD;
            memWrite = 1'b1;
            pcWrite  = bus.mem_ready;
         end
         BR: begin
            aluOp   = ALU_SUB;
            pcWrite = 1'b1;
            pcSrc   = bus.zero ? PC_SRC_BR : PC_SRC_INC;
         end
         JMP: begin
            pcWrite = 1'b1;
            pcSrc   = PC_SRC_JMP;
         end
         default: isHalted = 1'b1;
      endcase
      // Reset silences every enable immediately, including an in-flight memory request.
      if (rst) begin
         irWrite  = 1'b0;
         pcWrite  = 1'b0;
         pcSrc    = PC_SRC_INC;
         regWrite = 1'b0;
         regDst   = 1'b0;
         memToReg = 1'b0;
         aluSrc   = 1'b0;
         aluOp    = ALU_AND;
         memRead  = 1'b0;
         memWrite = 1'b0;
         isHalted = 1'b0;
      end
   end

   assign bus.ir_write   = irWrite;
   assign bus.pc_write   = pcWrite;
   assign bus.pc_src     = pcSrc;
   assign bus.reg_write  = regWrite;
   assign bus.reg_dst    = regDst;
   assign bus.mem_to_reg = memToReg;
   assign bus.alu_src    = aluSrc;
   assign bus.alu_op     = ALU_OP_W'(aluOp);
   assign bus.mem_read   = memRead;
   assign bus.mem_write  = memWrite;
   assign bus.halted     = isHalted;
   assign bus.err_code   = errCode;
   assign bus.retired    = retiredCnt;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected output vectors are queued as each
// cycle's inputs are driven and compared at the following falling edge.
module tb_multicycle_ctrl;

   typedef struct packed {
      logic        ir_write;
      logic        pc_write;
      logic [1:0]  pc_src;
      logic        reg_write;
      logic        reg_dst;
      logic        mem_to_reg;
      logic        alu_src;
      logic [3:0]  alu_op;
      logic        mem_read;
      logic        mem_write;
      logic        halted;
      logic [1:0]  err_code;
      logic [15:0] retired;
   } outv_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   multicycle_ctrl_if #(.ALU_OP_W(4), .RET_W(16)) bus ();

   multicycle_ctrl #(.ALU_OP_W(4), .TMO_W(4), .TMO_MAX(15), .RET_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   int          errors = 0;
   int          checks = 0;
   outv_t       expQ[$];
   string       tagQ[$];
   logic [15:0] expRet = '0;
   logic [1:0]  expErr = '0;

   function automatic outv_t obs();
      outv_t o;
      o.ir_write   = bus.ir_write;
      o.pc_write   = bus.pc_write;
      o.pc_src     = bus.pc_src;
      o.reg_write  = bus.reg_write;
      o.reg_dst    = bus.reg_dst;
      o.mem_to_reg = bus.mem_to_reg;
      o.alu_src    = bus.alu_src;
      o.alu_op     = bus.alu_op;
      o.mem_read   = bus.mem_read;
      o.mem_write  = bus.mem_write;
      o.halted     = bus.halted;
      o.err_code   = bus.err_code;
      o.retired    = bus.retired;
      return o;
   endfunction

   function automatic outv_t base();
      outv_t e = '0;
      e.retired  = expRet;
      e.err_code = expErr;
      return e;
   endfunction

   task automatic setIn(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy);
      bus.opcode    = op;
      bus.funct     = fn;
      bus.zero      = z;
      bus.mem_ready = rdy;
   endtask

   task automatic checkOut();
      outv_t e, o;
      string t;
      e = expQ.pop_front();
      t = tagQ.pop_front();
      o = obs();
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", t, o, e);
      end
   endtask

   task automatic cyc(input outv_t e, input string tag);
      expQ.push_back(e);
      tagQ.push_back(tag);
      @(negedge clk);
      checkOut();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset(input string nm);
      rst = 1'b1;
      cyc(base(), {nm, "_rst"});
      expRet = '0;
      expErr = 2'd0;
      rst = 1'b0;
   endtask

   task automatic fetchDec(input logic [5:0] op, input logic [5:0] fn, input string nm);
      outv_t e;
      setIn(op, fn, 1'b0, 1'b0);
      e = base(); e.ir_write = 1'b1;
      cyc(e, {nm, "_fetch"});
      cyc(base(), {nm, "_dec"});
   endtask

   task automatic runR(input logic [5:0] fn, input logic [3:0] aop, input string nm);
      outv_t e;
      fetchDec(6'h00, fn, nm);
      e = base(); e.alu_op = aop;
      cyc(e, {nm, "_exr"});
      e.reg_write = 1'b1; e.reg_dst = 1'b1; e.pc_write = 1'b1;
      cyc(e, {nm, "_wbr"});
      expRet++;
   endtask

   task automatic runLw(input int waits, input string nm);
      outv_t e;
      fetchDec(6'h23, 6'h00, nm);
      e = base(); e.alu_src = 1'b1; e.alu_op = 4'd2;
      cyc(e, {nm, "_addr"});
      e.mem_read = 1'b1;
      for (int i = 0; i < waits; i++) begin
         bus.mem_ready = 1'b0;
         cyc(e, {nm, "_wait"});
      end
      bus.mem_ready = 1'b1;
      cyc(e, {nm, "_rdy"});
      bus.mem_ready = 1'b0;
      e = base(); e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.pc_write = 1'b1;
      cyc(e, {nm, "_wbmem"});
      expRet++;
   endtask

   task automatic runSw(input int waits, input string nm);
      outv_t e;
      fetchDec(6'h2B, 6'h00, nm);
      e = base(); e.alu_src = 1'b1; e.alu_op = 4'd2;
      cyc(e, {nm, "_addr"});
      e.mem_write = 1'b1;
      for (int i = 0; i < waits; i++) begin
         bus.mem_ready = 1'b0;
         cyc(e, {nm, "_wait"});
      end
      bus.mem_ready = 1'b1;
      e.pc_write = 1'b1;
      cyc(e, {nm, "_rdy"});
      bus.mem_ready = 1'b0;
      expRet++;
   endtask

   task automatic runBeq(input logic z, input string nm);
      outv_t e;
      fetchDec(6'h04, 6'h00, nm);
      bus.zero = z;
      e = base(); e.alu_op = 4'd6; e.pc_write = 1'b1; e.pc_src = z ? 2'd1 : 2'd0;
      cyc(e, {nm, "_br"});
      bus.zero = 1'b0;
      expRet++;
   endtask

   task automatic runIllegal(input logic [5:0] op, input logic [5:0] fn, input string nm);
      outv_t e;
      fetchDec(op, fn, nm);
      expErr = 2'd1;
      e = base(); e.halted = 1'b1;
      for (int i = 0; i < 3; i++) begin
         setIn(6'h00, 6'h20, 1'b1, 1'b1);
         cyc(e, {nm, "_halt"});
      end
   endtask

   initial begin
      outv_t e;
      setIn(6'h00, 6'h20, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      cyc(base(), "reset");
      rst = 1'b0;

      runR(6'h20, 4'd2, "r_add");
      runR(6'h22, 4'd6, "r_sub");
      runR(6'h24, 4'd0, "r_and");
      runR(6'h25, 4'd1, "r_or");
      runR(6'h2A, 4'd7, "r_slt");

      fetchDec(6'h08, 6'h2A, "addi");
      e = base(); e.alu_src = 1'b1; e.alu_op = 4'd2;
      cyc(e, "addi_exi");
      e.reg_write = 1'b1; e.pc_write = 1'b1;
      cyc(e, "addi_wbi");
      expRet++;

      runLw(3, "lw3");
      runLw(15, "lw_edge");
      runBeq(1'b1, "beq_taken");
      runBeq(1'b0, "beq_not");

      fetchDec(6'h02, 6'h00, "jmp");
      e = base(); e.pc_write = 1'b1; e.pc_src = 2'd2;
      cyc(e, "jmp_exec");
      expRet++;

      runSw(0, "sw0");
      runSw(2, "sw2");

      e = base(); e.ir_write = 1'b1;
      cyc(e, "retired_count");

      doReset("pre_ill");
      runIllegal(6'h3F, 6'h00, "ill_op");
      doReset("ill_op");
      runIllegal(6'h00, 6'h03, "ill_fn");
      doReset("ill_fn");

      runR(6'h20, 4'd2, "pre_mid");
      fetchDec(6'h23, 6'h00, "rstmid");
      e = base(); e.alu_src = 1'b1; e.alu_op = 4'd2;
      cyc(e, "rstmid_addr");
      e.mem_read = 1'b1;
      cyc(e, "rstmid_memrd");
      doReset("rstmid");
      e = base(); e.ir_write = 1'b1;
      cyc(e, "rstmid_fetch");
      doReset("pre_tmo");

      fetchDec(6'h2B, 6'h00, "swtmo");
      e = base(); e.alu_src = 1'b1; e.alu_op = 4'd2;
      cyc(e, "swtmo_addr");
      e.mem_write = 1'b1;
      for (int i = 0; i < 16; i++) begin
         cyc(e, "swtmo_wait");
      end
      expErr = 2'd2;
      e = base(); e.halted = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.mem_ready = (i >= 2);
         cyc(e, "swtmo_halt");
      end
      doReset("final");
      e = base(); e.ir_write = 1'b1;
      cyc(e, "final_fetch");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
